// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared state encoding, edge-vector bit positions and default run rate
package exec_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        RUN   = 3'd2,
        FAST  = 3'd3,
        EDIT  = 3'd4,
        CLEAR = 3'd5
    } state_t;
    localparam int DEFAULT_SLOW_DIV = 25_000_000;
    localparam int E_NEXT = 0;
    localparam int E_RUN = 1;
    localparam int E_SPEED = 2;
    localparam int E_SEND = 3;
    localparam int E_ROM = 4;
endpackage

// File: rtl/edge_rise.sv
// edge_rise: per-bit rising-edge pulse from one registered copy of each input
module edge_rise #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_sig,
    output logic [W-1:0] o_rise
);
    logic [W-1:0] r_prev;
    always_ff @(posedge clk) begin
        if (rst) r_prev <= '0;
        else r_prev <= i_sig;
    end
    assign o_rise = i_sig & ~r_prev;
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: turns board buttons into core step pulses, ROM edit writes and a full-ROM clear,
// with slow/fast free-running rates and a pc breakpoint
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int SLOW_DIV = DEFAULT_SLOW_DIV,
    parameter int FAST_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rstROM,
    input  logic              next,
    input  logic              run,
    input  logic              speedRun,
    input  logic              edit,
    input  logic [ADDR_W-1:0] unit,
    input  logic [DATA_W-1:0] code,
    input  logic              send,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              step_en,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic [2:0]        mode,
    output logic              busy
);
    localparam int CNT_W = $clog2(SLOW_DIV > FAST_DIV ? SLOW_DIV : FAST_DIV);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       w_rise;
    logic             w_due;
    logic             w_bp;
    logic             w_clr_last;
    logic             w_clr_go;
    logic             w_active;

    edge_rise #(.W(5)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .i_sig ({rstROM, send, speedRun, run, next}),
        .o_rise(w_rise)
    );

    assign w_due = r_cnt == (r_state == RUN ? SLOW_LAST : FAST_LAST);
    assign w_bp = bp_en && pc == bp_addr;
    assign w_clr_last = &rom_addr;
    // edit outranks a clear request from IDLE, so a clear only starts when edit agrees with the state
    assign w_clr_go = w_rise[E_ROM] && ((r_state == IDLE && !edit) || (r_state == EDIT && edit));
    assign w_active = r_state == STEP || r_state == RUN || r_state == FAST;
    assign mode = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            step_en   <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            step_en <= 1'b0;
            rom_we  <= 1'b0;
            busy    <= 1'b0;
            r_cnt   <= '0;
            if (r_state == CLEAR) begin
                if (w_clr_last) r_state <= edit ? EDIT : IDLE;
                else begin
                    rom_we   <= 1'b1;
                    busy     <= 1'b1;
                    rom_addr <= rom_addr + 1'b1;
                end
            end else if (w_clr_go) begin
                r_state   <= CLEAR;
                rom_we    <= 1'b1;
                busy      <= 1'b1;
                rom_addr  <= '0;
                rom_wdata <= '0;
            end else if (edit) begin
                r_state <= EDIT;
                if (r_state == EDIT && w_rise[E_SEND]) begin
                    rom_we    <= 1'b1;
                    rom_addr  <= unit;
                    rom_wdata <= code;
                end
            end else if (halt && w_active) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise[E_NEXT]) begin
                            r_state <= STEP;
                            step_en <= 1'b1;
                        end else if (w_rise[E_RUN]) r_state <= RUN;
                        else if (w_rise[E_SPEED]) r_state <= FAST;
                    end
                    RUN, FAST: begin
                        if (w_due && w_bp) r_state <= IDLE;
                        else begin
                            step_en <= w_due;
                            r_cnt   <= w_due ? '0 : r_cnt + 1'b1;
                            if (w_rise[E_RUN]) begin
                                r_state <= r_state == RUN ? IDLE : RUN;
                                r_cnt   <= '0;
                            end else if (w_rise[E_SPEED]) begin
                                r_state <= r_state == FAST ? IDLE : FAST;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed test-plan scenarios then random buttons, all checked against a
// cycle model that tracks elapsed time in RUN/FAST and remaining writes in CLEAR
module tb_exec_ctrl;
    localparam int SLOW = 5;
    localparam int FAST = 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rstROM = 1'b0, next = 1'b0, run = 1'b0, speedRun = 1'b0;
    logic       edit = 1'b0, send = 1'b0, halt = 1'b0, bp_en = 1'b0;
    logic [3:0] unit = '0, pc = '0, bp_addr = '0;
    logic [7:0] code = '0;
    logic       step_en, rom_we, busy;
    logic [3:0] rom_addr;
    logic [7:0] rom_wdata;
    logic [2:0] mode;

    int n_vec = 0;
    int n_err = 0;
    int m_mode = 0, m_step = 0, m_we = 0, m_addr = 0, m_wdata = 0, m_busy = 0;
    int m_elapsed = 0, m_left = 0;
    bit p_next, p_run, p_speed, p_send, p_rom;

    exec_ctrl #(.DATA_W(8), .ADDR_W(4), .SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
        .clk(clk), .rst(rst), .rstROM(rstROM), .next(next), .run(run), .speedRun(speedRun),
        .edit(edit), .unit(unit), .code(code), .send(send), .halt(halt), .pc(pc),
        .bp_en(bp_en), .bp_addr(bp_addr), .step_en(step_en), .rom_we(rom_we),
        .rom_addr(rom_addr), .rom_wdata(rom_wdata), .mode(mode), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_clear();
        m_mode = 5;
        m_we = 1;
        m_busy = 1;
        m_addr = 0;
        m_wdata = 0;
        m_left = DEPTH - 1;
    endtask

    task automatic model_step();
        bit e_next, e_run, e_speed, e_send, e_rom, due;
        int div;
        e_next = next && !p_next;
        e_run = run && !p_run;
        e_speed = speedRun && !p_speed;
        e_send = send && !p_send;
        e_rom = rstROM && !p_rom;
        {p_next, p_run, p_speed, p_send, p_rom} = {next, run, speedRun, send, rstROM};
        m_step = 0;
        m_we = 0;
        m_busy = 0;
        if (rst) begin
            {p_next, p_run, p_speed, p_send, p_rom} = '0;
            m_mode = 0;
            m_addr = 0;
            m_wdata = 0;
            m_elapsed = 0;
        end else if (m_mode == 5) begin
            if (m_left == 0) m_mode = edit ? 4 : 0;
            else begin
                m_we = 1;
                m_busy = 1;
                m_addr = DEPTH - m_left;
                m_left--;
            end
        end else if (edit) begin
            if (m_mode == 4 && e_rom) start_clear();
            else begin
                if (m_mode == 4 && e_send) begin
                    m_we = 1;
                    m_addr = unit;
                    m_wdata = code;
                end
                m_mode = 4;
            end
        end else if (halt && (m_mode == 1 || m_mode == 2 || m_mode == 3)) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_elapsed = 0;
            if (e_rom) start_clear();
            else if (e_next) begin
                m_mode = 1;
                m_step = 1;
            end else if (e_run) m_mode = 2;
            else if (e_speed) m_mode = 3;
        end else if (m_mode == 1 || m_mode == 4) begin
            m_mode = 0;
        end else begin
            div = m_mode == 2 ? SLOW : FAST;
            due = (m_elapsed % div) == div - 1;
            m_elapsed++;
            if (due && bp_en && pc == bp_addr) m_mode = 0;
            else begin
                m_step = due;
                if (e_run) begin
                    m_mode = m_mode == 2 ? 0 : 2;
                    m_elapsed = 0;
                end else if (e_speed) begin
                    m_mode = m_mode == 3 ? 0 : 3;
                    m_elapsed = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("step_en", step_en, m_step);
        chk("rom_we", rom_we, m_we);
        chk("rom_addr", rom_addr, m_addr);
        chk("rom_wdata", rom_wdata, m_wdata);
        chk("mode", mode, m_mode);
        chk("busy", busy, m_busy);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mode", mode, 0);
        chk("rst_step", step_en, 0);
        chk("rst_we", rom_we, 0);
        chk("rst_busy", busy, 0);
        repeat (7) tick();
        next = 1'b1;
        tick();
        chk("step_pulse", step_en, 1);
        chk("step_mode", mode, 1);
        tick();
        chk("step_once", step_en, 0);
        chk("step_back", mode, 0);
        next = 1'b0;
        tick();
        run = 1'b1;
        tick();
        chk("run_mode", mode, 2);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("run_rate", step_en, k % SLOW == 0);
        end
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        chk("run_stop", mode, 0);
        run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("run_quiet", step_en, 0);
        end
        bp_en = 1'b1;
        bp_addr = 4'h3;
        pc = 4'h3;
        speedRun = 1'b1;
        tick();
        chk("fast_mode", mode, 3);
        speedRun = 1'b0;
        tick();
        tick();
        chk("bp_step", step_en, 0);
        chk("bp_mode", mode, 0);
        next = 1'b1;
        tick();
        chk("bp_manual", step_en, 1);
        next = 1'b0;
        tick();
        bp_en = 1'b0;
        edit = 1'b1;
        tick();
        chk("edit_mode", mode, 4);
        unit = 4'hA;
        code = 8'h7F;
        send = 1'b1;
        tick();
        chk("edit_we", rom_we, 1);
        chk("edit_addr", rom_addr, 4'hA);
        chk("edit_data", rom_wdata, 8'h7F);
        tick();
        chk("edit_held", rom_we, 0);
        send = 1'b0;
        tick();
        rstROM = 1'b1;
        tick();
        chk("clr_start", busy, 1);
        chk("clr_addr0", rom_addr, 0);
        rstROM = 1'b0;
        edit = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            chk("clr_addr", rom_addr, i);
            chk("clr_we", rom_we, 1);
            chk("clr_data", rom_wdata, 0);
        end
        tick();
        chk("clr_done", mode, 0);
        chk("clr_idle", busy, 0);
        rstROM = 1'b1;
        tick();
        rstROM = 1'b0;
        repeat (7) tick();
        chk("clr_at7", rom_addr, 7);
        rst = 1'b1;
        tick();
        chk("abort_mode", mode, 0);
        chk("abort_we", rom_we, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (4) tick();
        halt = 1'b1;
        tick();
        chk("halt_step", step_en, 0);
        chk("halt_mode", mode, 0);
        halt = 1'b0;
        tick();
        speedRun = 1'b1;
        tick();
        speedRun = 1'b0;
        tick();
        edit = 1'b1;
        tick();
        chk("fast_edit", mode, 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("edit_nostep", step_en, 0);
        end
        edit = 1'b0;
        tick();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) next = ~next;
            if ($urandom_range(0, 7) == 0) run = ~run;
            if ($urandom_range(0, 7) == 0) speedRun = ~speedRun;
            if ($urandom_range(0, 5) == 0) send = ~send;
            if ($urandom_range(0, 39) == 0) edit = ~edit;
            if ($urandom_range(0, 29) == 0) rstROM = ~rstROM;
            if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
            halt = $urandom_range(0, 29) == 0;
            rst = $urandom_range(0, 499) == 0;
            pc = $urandom_range(0, 3) == 0 ? bp_addr : 4'($urandom);
            unit = 4'($urandom);
            code = 8'($urandom);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
